reg_file_sb: RTL and testbench
==============================

# reg_file_sb

Parametrised register file for the RV32IM pipeline. It has two combinational read ports with write-through bypass, one synchronous write port, and a per-register busy scoreboard with a pending-write counter. It sits between the decode/issue stage, which reads operands and allocates destinations, and the writeback stage, which writes results and retires allocations. It replaces the fixed 32x32 register file: the register-0 behaviour is now selectable, and it adds hazard tracking for issue-stage stall logic.

## Interface
- DATA_WIDTH, 32, width of each register
- ADDR_WIDTH, 5, address width; DEPTH = 2**ADDR_WIDTH registers
- ZERO_REG, 1, 1 = register 0 hardwired to zero and never busy; 0 = register 0 is ordinary storage

- CLOCK  in  1  sole clock, rising edge
- RESET  in  1  asynchronous, active-high reset
- IN  in  DATA_WIDTH  write data
- INADDRESS  in  ADDR_WIDTH  write address
- WRITE  in  1  write enable; also retires the busy bit of INADDRESS
- ALLOC  in  1  issue-time allocation enable
- ALLOCADDRESS  in  ADDR_WIDTH  destination register being allocated
- OUT1ADDRESS, OUT2ADDRESS  in  ADDR_WIDTH  read addresses
- OUT1, OUT2  out  DATA_WIDTH  read data, combinational
- BUSY1, BUSY2  out  1  pending-write flag for OUT1ADDRESS / OUT2ADDRESS, combinational
- PENDING  out  ADDR_WIDTH+1  number of registers currently busy

## Operation
- State:
  - regs[DEPTH] of DATA_WIDTH bits
  - busy[DEPTH] bits
  - cnt, ADDR_WIDTH+1 bits; PENDING = cnt at all times
- Reset (RESET=1, any time, independent of CLOCK):
  - all regs = 0, all busy = 0, cnt = 0
  - state is held while RESET=1; WRITE/ALLOC ignored
- Write on a rising edge with WRITE=1:
  - regs[INADDRESS] <= IN
  - busy[INADDRESS] <= 0
  - Exception: if ZERO_REG=1 and INADDRESS=0, no effect
- Alloc on a rising edge with ALLOC=1:
  - busy[ALLOCADDRESS] <= 1
  - Exception: if ZERO_REG=1 and ALLOCADDRESS=0, no effect
- WRITE and ALLOC to the same address in the same cycle:
  - ALLOC wins; busy stays/becomes 1 (the new producer supersedes)
  - data is still written
- Counter: cnt_next = cnt + (number of busy bits 0->1) - (number of busy bits 1->0)
  - computed from the actual transitions, so the result is always in the range -1..+1
  - WRITE to a non-busy register: no decrement
  - ALLOC to an already-busy register: no increment
  - invariant: cnt == popcount(busy)
- Read port n (combinational):
  - if ZERO_REG=1 and OUTnADDRESS=0: OUTn=0, BUSYn=0
  - else if WRITE=1 and INADDRESS==OUTnADDRESS (bypass): OUTn=IN; BUSYn=0, unless ALLOC=1 and ALLOCADDRESS==OUTnADDRESS
  - else: OUTn=regs[OUTnADDRESS], BUSYn=busy[OUTnADDRESS]
- Both read ports are independent and may address the same register.

## Timing
- Write and alloc latency: visible in state 1 CLOCK edge after assertion; visible on OUTn/BUSYn the same cycle via bypass.
- Read latency: 0 cycles; outputs settle combinationally from addresses and state.
- No simulation delays (#) in RTL.
- RESET assertion clears state and outputs immediately (asynchronously).
- RESET deassertion: the first effective write/alloc is at the first rising edge with RESET=0.
- Reset values of outputs: OUT1=OUT2=0, BUSY1=BUSY2=0, PENDING=0.
- cnt never exceeds DEPTH (DEPTH-1 when ZERO_REG=1) and never underflows. The bench asserts both every cycle.

## Test plan
- Reset then read all addresses: OUT1/OUT2=0, BUSY1/BUSY2=0, PENDING=0. Then assert RESET mid-run after writes: all of these return to 0 before the next edge.
- Write 0xDEADBEEF to x5, read x5 on both ports in the same cycle: OUT1=OUT2=0xDEADBEEF (bypass). Next cycle, with WRITE=0: still 0xDEADBEEF.
- ZERO_REG=1: write 0x12345678 to x0 and ALLOC x0, read x0: OUT=0, BUSY=0, PENDING=0. Repeat with ZERO_REG=0: OUT=0x12345678, BUSY=1, PENDING=1.
- ALLOC x3, x7, x3 in successive cycles: PENDING=1,2,2. Then WRITE x7 with value 7: BUSY for x7=0 in the write cycle, PENDING=1 after the edge. Then WRITE x9 (not busy): PENDING stays 1.
- Same-cycle WRITE x4 (0xA5) + ALLOC x4, with x4 previously busy: after the edge busy[x4]=1, PENDING unchanged, OUT=0xA5, BUSY=1. Same-cycle WRITE x3 + ALLOC x8, with x3 busy: PENDING unchanged (net 0).
- Random stress for 10k cycles with DATA_WIDTH=64, ADDR_WIDTH=4: compare against a reference model. PENDING == popcount(busy) every cycle.

Source files
------------

// File: rtl/reg_file_sb.sv
// reg_file_sb
//   Register file with a per-register busy scoreboard for the RV32IM pipeline.
//   Two combinational read ports with write-through bypass, one synchronous
//   write port that also retires the destination's busy bit, and an issue-time
//   allocation port that marks a destination busy. PENDING counts busy regs.
//
// Ports
//   CLOCK                      rising-edge clock
//   RESET                      asynchronous active-high reset
//   IN / INADDRESS / WRITE     write data, address, enable (retires busy)
//   ALLOC / ALLOCADDRESS       allocate destination (sets busy)
//   OUT1ADDRESS / OUT2ADDRESS  read addresses
//   OUT1 / OUT2                read data (combinational, bypassed)
//   BUSY1 / BUSY2              pending-write flag of the read address
//   PENDING                    number of busy registers
module reg_file_sb #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int ZERO_REG   = 1
) (
   input  logic                  CLOCK,
   input  logic                  RESET,
   input  logic [DATA_WIDTH-1:0] IN,
   input  logic [ADDR_WIDTH-1:0] INADDRESS,
   input  logic                  WRITE,
   input  logic                  ALLOC,
   input  logic [ADDR_WIDTH-1:0] ALLOCADDRESS,
   input  logic [ADDR_WIDTH-1:0] OUT1ADDRESS,
   input  logic [ADDR_WIDTH-1:0] OUT2ADDRESS,
   output logic [DATA_WIDTH-1:0] OUT1,
   output logic [DATA_WIDTH-1:0] OUT2,
   output logic                  BUSY1,
   output logic                  BUSY2,
   output logic [ADDR_WIDTH:0]   PENDING
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam bit ZERO_EN = (ZERO_REG != 0);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
   localparam logic [ADDR_WIDTH-1:0] ADDR_PAD  = {ADDR_WIDTH{1'b0}};

   logic [DATA_WIDTH-1:0] regs_q [DEPTH];
   logic [DATA_WIDTH-1:0] regs_d [DEPTH];
   logic [DEPTH-1:0]      busy_q;
   logic [DEPTH-1:0]      busy_d;
   logic [ADDR_WIDTH:0]   cnt_q;
   logic [ADDR_WIDTH:0]   cnt_d;

   // Raw enables for the bypass path; suppressed while reset holds the outputs at 0.
   logic wr_byp_s;
   logic al_byp_s;
   // Enables that actually change state (register 0 excluded when hardwired).
   logic wr_en_s;
   logic al_en_s;
   logic rise_s;
   logic fall_s;
   logic [DATA_WIDTH:0] rd1_s;
   logic [DATA_WIDTH:0] rd2_s;

   // Read one port: returns {busy, data} with zero-register and bypass handling.
   function automatic logic [DATA_WIDTH:0] read_port(input logic [ADDR_WIDTH-1:0] addr);
      logic [DATA_WIDTH:0] res;
      if (ZERO_EN && (addr == ADDR_ZERO)) begin
         res = {(DATA_WIDTH + 1){1'b0}};
      end else if (wr_byp_s && (INADDRESS == addr)) begin
         // A same-cycle allocation of this address supersedes the retiring write.
         res = {(al_byp_s && (ALLOCADDRESS == addr)), IN};
      end else begin
         res = {busy_q[addr], regs_q[addr]};
      end
      return res;
   endfunction

   // Qualify write/alloc enables for reset and the hardwired register 0.
   always_comb begin
      wr_byp_s = WRITE & ~RESET;
      al_byp_s = ALLOC & ~RESET;
      wr_en_s  = wr_byp_s & ~(ZERO_EN & (INADDRESS == ADDR_ZERO));
      al_en_s  = al_byp_s & ~(ZERO_EN & (ALLOCADDRESS == ADDR_ZERO));
   end

   // Next-state for data, busy bits and the pending counter.
   always_comb begin
      regs_d = regs_q;
      busy_d = busy_q;
      rise_s = 1'b0;
      fall_s = 1'b0;
      if (wr_en_s) begin
         regs_d[INADDRESS] = IN;
         busy_d[INADDRESS] = 1'b0;
      end else begin
         regs_d = regs_q;
      end
      // Applied after the write so ALLOC wins on an address collision.
      if (al_en_s) begin
         busy_d[ALLOCADDRESS] = 1'b1;
      end else begin
         rise_s = 1'b0;
      end
      // Count real transitions only: at most one bit can rise and one can fall.
      rise_s = al_en_s & ~busy_q[ALLOCADDRESS];
      fall_s = wr_en_s & busy_q[INADDRESS] & ~(al_en_s & (ALLOCADDRESS == INADDRESS));
      cnt_d  = cnt_q + {ADDR_PAD, rise_s} - {ADDR_PAD, fall_s};
   end

   // State registers with asynchronous clear.
   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= {DATA_WIDTH{1'b0}};
         end
         busy_q <= {DEPTH{1'b0}};
         cnt_q  <= {(ADDR_WIDTH + 1){1'b0}};
      end else begin
         regs_q <= regs_d;
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
      end
   end

   // Combinational read ports.
   always_comb begin
      rd1_s = read_port(OUT1ADDRESS);
      rd2_s = read_port(OUT2ADDRESS);
   end

   assign OUT1    = rd1_s[DATA_WIDTH-1:0];
   assign BUSY1   = rd1_s[DATA_WIDTH];
   assign OUT2    = rd2_s[DATA_WIDTH-1:0];
   assign BUSY2   = rd2_s[DATA_WIDTH];
   assign PENDING = cnt_q;

endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;

   logic clk;
   logic rst;

   // Instance A: 32x32, register 0 hardwired.
   logic [31:0] a_in;
   logic [4:0]  a_inaddr;
   logic        a_write;
   logic        a_alloc;
   logic [4:0]  a_allocaddr;
   logic [4:0]  a_r1;
   logic [4:0]  a_r2;
   logic [31:0] a_out1;
   logic [31:0] a_out2;
   logic        a_busy1;
   logic        a_busy2;
   logic [5:0]  a_pending;

   // Instance B: 16x64, register 0 ordinary.
   logic [63:0] b_in;
   logic [3:0]  b_inaddr;
   logic        b_write;
   logic        b_alloc;
   logic [3:0]  b_allocaddr;
   logic [3:0]  b_r1;
   logic [3:0]  b_r2;
   logic [63:0] b_out1;
   logic [63:0] b_out2;
   logic        b_busy1;
   logic        b_busy2;
   logic [4:0]  b_pending;

   int checks = 0;
   int errors = 0;

   reg_file_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1)) dut_a (
      .CLOCK(clk), .RESET(rst), .IN(a_in), .INADDRESS(a_inaddr), .WRITE(a_write),
      .ALLOC(a_alloc), .ALLOCADDRESS(a_allocaddr), .OUT1ADDRESS(a_r1), .OUT2ADDRESS(a_r2),
      .OUT1(a_out1), .OUT2(a_out2), .BUSY1(a_busy1), .BUSY2(a_busy2), .PENDING(a_pending)
   );

   reg_file_sb #(.DATA_WIDTH(64), .ADDR_WIDTH(4), .ZERO_REG(0)) dut_b (
      .CLOCK(clk), .RESET(rst), .IN(b_in), .INADDRESS(b_inaddr), .WRITE(b_write),
      .ALLOC(b_alloc), .ALLOCADDRESS(b_allocaddr), .OUT1ADDRESS(b_r1), .OUT2ADDRESS(b_r2),
      .OUT1(b_out1), .OUT2(b_out2), .BUSY1(b_busy1), .BUSY2(b_busy2), .PENDING(b_pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counter bounds every cycle (outside reset).
   always @(negedge clk) begin
      if (!rst) begin
         checks++;
         if (a_pending > 6'd31) begin
            errors++;
            $display("FAIL a_pending_bound got %0d max 31", a_pending);
         end
         checks++;
         if (b_pending > 5'd16) begin
            errors++;
            $display("FAIL b_pending_bound got %0d max 16", b_pending);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      a_write = 1'b0; a_alloc = 1'b0; a_in = 32'd0; a_inaddr = 5'd0; a_allocaddr = 5'd0;
      a_r1 = 5'd0; a_r2 = 5'd0;
      b_write = 1'b0; b_alloc = 1'b0; b_in = 64'd0; b_inaddr = 4'd0; b_allocaddr = 4'd0;
      b_r1 = 4'd0; b_r2 = 4'd0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      #2;
      for (int i = 0; i < 32; i++) begin
         a_r1 = i[4:0];
         a_r2 = 5'd31 - i[4:0];
         #1;
         checks++;
         if (a_out1 !== 32'd0 || a_out2 !== 32'd0 || a_busy1 !== 1'b0 || a_busy2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_read addr %0d got out1=%h out2=%h b1=%b b2=%b want 0", i, a_out1, a_out2, a_busy1, a_busy2);
         end
      end
      checks++;
      if (a_pending !== 6'd0 || b_pending !== 5'd0) begin
         errors++;
         $display("FAIL reset_pending got a=%0d b=%0d want 0", a_pending, b_pending);
      end
      @(negedge clk);
      rst = 1'b0;
      step();
      // Populate some state, then reset asynchronously mid-cycle.
      a_write = 1'b1; a_inaddr = 5'd1; a_in = 32'h0000_0011;
      a_alloc = 1'b1; a_allocaddr = 5'd2;
      step();
      a_write = 1'b0; a_alloc = 1'b0;
      a_r1 = 5'd1; a_r2 = 5'd2;
      #1;
      checks++;
      if (a_out1 !== 32'h0000_0011 || a_busy2 !== 1'b1 || a_pending !== 6'd1) begin
         errors++;
         $display("FAIL pre_reset_state got out1=%h busy2=%b pend=%0d want 00000011 1 1", a_out1, a_busy2, a_pending);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (a_out1 !== 32'd0 || a_busy2 !== 1'b0 || a_pending !== 6'd0) begin
         errors++;
         $display("FAIL midrun_reset got out1=%h busy2=%b pend=%0d want 0 0 0", a_out1, a_busy2, a_pending);
      end
      #1;
      rst = 1'b0;
      step();
   endtask

   task automatic test_bypass();
      a_write = 1'b1; a_inaddr = 5'd5; a_in = 32'hDEAD_BEEF;
      a_r1 = 5'd5; a_r2 = 5'd5;
      #1;
      checks++;
      if (a_out1 !== 32'hDEAD_BEEF || a_out2 !== 32'hDEAD_BEEF || a_busy1 !== 1'b0) begin
         errors++;
         $display("FAIL bypass_same_cycle got out1=%h out2=%h busy1=%b want deadbeef deadbeef 0", a_out1, a_out2, a_busy1);
      end
      step();
      a_write = 1'b0; a_in = 32'd0;
      #1;
      checks++;
      if (a_out1 !== 32'hDEAD_BEEF || a_out2 !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL bypass_stored got out1=%h out2=%h want deadbeef", a_out1, a_out2);
      end
   endtask

   task automatic test_zero_reg();
      a_write = 1'b1; a_inaddr = 5'd0; a_in = 32'h1234_5678;
      a_alloc = 1'b1; a_allocaddr = 5'd0; a_r1 = 5'd0;
      b_write = 1'b1; b_inaddr = 4'd0; b_in = 64'h0000_0000_1234_5678;
      b_alloc = 1'b1; b_allocaddr = 4'd0; b_r1 = 4'd0;
      #1;
      checks++;
      if (a_out1 !== 32'd0 || a_busy1 !== 1'b0) begin
         errors++;
         $display("FAIL zero_reg1_bypass got out=%h busy=%b want 0 0", a_out1, a_busy1);
      end
      checks++;
      if (b_out1 !== 64'h0000_0000_1234_5678 || b_busy1 !== 1'b1) begin
         errors++;
         $display("FAIL zero_reg0_bypass got out=%h busy=%b want 12345678 1", b_out1, b_busy1);
      end
      step();
      idle_inputs();
      #1;
      checks++;
      if (a_out1 !== 32'd0 || a_busy1 !== 1'b0 || a_pending !== 6'd0) begin
         errors++;
         $display("FAIL zero_reg1_state got out=%h busy=%b pend=%0d want 0 0 0", a_out1, a_busy1, a_pending);
      end
      checks++;
      if (b_out1 !== 64'h0000_0000_1234_5678 || b_busy1 !== 1'b1 || b_pending !== 5'd1) begin
         errors++;
         $display("FAIL zero_reg0_state got out=%h busy=%b pend=%0d want 12345678 1 1", b_out1, b_busy1, b_pending);
      end
   endtask

   task automatic test_alloc_count();
      logic [5:0] exp_p [3];
      logic [4:0] seq [3];
      seq[0] = 5'd3; seq[1] = 5'd7; seq[2] = 5'd3;
      exp_p[0] = 6'd1; exp_p[1] = 6'd2; exp_p[2] = 6'd2;
      for (int i = 0; i < 3; i++) begin
         a_alloc = 1'b1; a_allocaddr = seq[i];
         step();
         checks++;
         if (a_pending !== exp_p[i]) begin
            errors++;
            $display("FAIL alloc_pending step %0d got %0d want %0d", i, a_pending, exp_p[i]);
         end
      end
      a_alloc = 1'b0;
      a_write = 1'b1; a_inaddr = 5'd7; a_in = 32'd7; a_r1 = 5'd7; a_r2 = 5'd3;
      #1;
      checks++;
      if (a_out1 !== 32'd7 || a_busy1 !== 1'b0 || a_busy2 !== 1'b1) begin
         errors++;
         $display("FAIL retire_bypass got out1=%h busy1=%b busy2=%b want 7 0 1", a_out1, a_busy1, a_busy2);
      end
      step();
      checks++;
      if (a_pending !== 6'd1) begin
         errors++;
         $display("FAIL retire_pending got %0d want 1", a_pending);
      end
      a_inaddr = 5'd9; a_in = 32'd9;
      step();
      a_write = 1'b0;
      checks++;
      if (a_pending !== 6'd1) begin
         errors++;
         $display("FAIL write_nonbusy_pending got %0d want 1", a_pending);
      end
   endtask

   task automatic test_same_cycle();
      a_alloc = 1'b1; a_allocaddr = 5'd4;
      step();
      checks++;
      if (a_pending !== 6'd2) begin
         errors++;
         $display("FAIL alloc_x4_pending got %0d want 2", a_pending);
      end
      a_write = 1'b1; a_inaddr = 5'd4; a_in = 32'h0000_00A5;
      a_alloc = 1'b1; a_allocaddr = 5'd4; a_r1 = 5'd4;
      #1;
      checks++;
      if (a_out1 !== 32'h0000_00A5 || a_busy1 !== 1'b1) begin
         errors++;
         $display("FAIL wr_alloc_bypass got out=%h busy=%b want a5 1", a_out1, a_busy1);
      end
      step();
      a_write = 1'b0; a_alloc = 1'b0;
      #1;
      checks++;
      if (a_out1 !== 32'h0000_00A5 || a_busy1 !== 1'b1 || a_pending !== 6'd2) begin
         errors++;
         $display("FAIL wr_alloc_state got out=%h busy=%b pend=%0d want a5 1 2", a_out1, a_busy1, a_pending);
      end
      a_write = 1'b1; a_inaddr = 5'd3; a_in = 32'd3;
      a_alloc = 1'b1; a_allocaddr = 5'd8;
      step();
      a_write = 1'b0; a_alloc = 1'b0; a_r1 = 5'd3; a_r2 = 5'd8;
      #1;
      checks++;
      if (a_pending !== 6'd2 || a_busy1 !== 1'b0 || a_busy2 !== 1'b1) begin
         errors++;
         $display("FAIL net_zero got pend=%0d b3=%b b8=%b want 2 0 1", a_pending, a_busy1, a_busy2);
      end
   endtask

   task automatic test_stress();
      logic [63:0] m_regs [16];
      logic [15:0] m_busy;
      logic [63:0] e_out1;
      logic [63:0] e_out2;
      logic        e_b1;
      logic        e_b2;
      int          pop;
      rst = 1'b1;
      idle_inputs();
      #1;
      rst = 1'b0;
      for (int i = 0; i < 16; i++) m_regs[i] = 64'd0;
      m_busy = 16'd0;
      for (int c = 0; c < 10000; c++) begin
         b_write = $urandom_range(0, 1) == 1;
         b_alloc = $urandom_range(0, 2) == 0;
         b_inaddr = 4'($urandom_range(0, 15));
         b_allocaddr = 4'($urandom_range(0, 15));
         b_in = {32'($urandom), 32'($urandom)};
         b_r1 = 4'($urandom_range(0, 15));
         b_r2 = ($urandom_range(0, 3) == 0) ? b_inaddr : 4'($urandom_range(0, 15));
         #1;
         e_out1 = m_regs[b_r1]; e_b1 = m_busy[b_r1];
         e_out2 = m_regs[b_r2]; e_b2 = m_busy[b_r2];
         if (b_write && b_inaddr == b_r1) begin
            e_out1 = b_in; e_b1 = b_alloc && (b_allocaddr == b_r1);
         end
         if (b_write && b_inaddr == b_r2) begin
            e_out2 = b_in; e_b2 = b_alloc && (b_allocaddr == b_r2);
         end
         checks++;
         if (b_out1 !== e_out1 || b_busy1 !== e_b1 || b_out2 !== e_out2 || b_busy2 !== e_b2) begin
            errors++;
            $display("FAIL stress_read cyc %0d got %h/%b %h/%b want %h/%b %h/%b", c,
                     b_out1, b_busy1, b_out2, b_busy2, e_out1, e_b1, e_out2, e_b2);
         end
         if (b_write) begin
            m_regs[b_inaddr] = b_in;
            m_busy[b_inaddr] = 1'b0;
         end
         if (b_alloc) m_busy[b_allocaddr] = 1'b1;
         step();
         pop = 0;
         for (int k = 0; k < 16; k++) pop += int'(m_busy[k]);
         checks++;
         if (int'(b_pending) != pop) begin
            errors++;
            $display("FAIL stress_pending cyc %0d got %0d want %0d", c, b_pending, pop);
         end
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_bypass();
      test_zero_reg();
      test_alloc_count();
      test_same_cycle();
      test_stress();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
